red_pitaya_trig_debounce: RTL and testbench
===========================================

RED_PITAYA_TRIG_DEBOUNCE -- requirements
Module: red_pitaya_trig_debounce

Interface
REQ-001 SHALL have parameter DEB_W, default 20, width of the debounce length and qualification counter.
REQ-002 SHALL have parameter GCNT_W, default 16, width of the glitch counter.
REQ-003 SHALL have port adc_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port adc_rstn_i  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port trig_ext_i  input  1  raw external trigger pin, asynchronous to adc_clk_i.
REQ-006 SHALL have port deb_len_i  input  DEB_W  qualification length N in clocks; N = max(deb_len_i,1).
REQ-007 SHALL have port en_i  input  1  high: edge pulses and glitch counting enabled.
REQ-008 SHALL have port gcnt_clr_i  input  1  synchronous clear of the glitch counter.
REQ-009 SHALL have port trig_p_o  output  1  one-cycle pulse on each qualified rising transition.
REQ-010 SHALL have port trig_n_o  output  1  one-cycle pulse on each qualified falling transition.
REQ-011 SHALL have port trig_lvl_o  output  1  debounced level.
REQ-012 SHALL have port gcnt_o  output  GCNT_W  count of rejected transitions, saturating.

Function
REQ-013 SHALL pass trig_ext_i through a two-flop synchronizer; FSM SHALL use only the second flop output (s).
REQ-014 SHALL implement FSM states STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-015 STABLE_LO: s=1 with N=1 -> STABLE_HI directly; s=1 with N>1 -> QUAL_HI, counter=1; else stay.
REQ-016 QUAL_HI: s=0 -> STABLE_LO, glitch event; s=1 and counter+1>=N -> STABLE_HI; else counter+1.
REQ-017 STABLE_HI and QUAL_LO SHALL mirror REQ-015/016 with polarities inverted.
REQ-018 Entering STABLE_HI from STABLE_LO/QUAL_HI SHALL set trig_p_o=1 for exactly the next cycle; likewise trig_n_o on entering STABLE_LO from QUAL_LO.
REQ-019 Latency: with input held at the new level, trig_p_o/trig_n_o SHALL be high in the cycle following the (N+1)th rising edge after the first edge sampling the new level at trig_ext_i.
REQ-020 trig_lvl_o SHALL be 1 in STABLE_HI and QUAL_LO, 0 otherwise, registered; it changes in the same cycle as the pulse.
REQ-021 trig_p_o and trig_n_o SHALL never be high simultaneously; minimum spacing between pulses is N cycles.
REQ-022 deb_len_i SHALL be sampled live each cycle; if lowered below current counter+1, transition SHALL occur at the next sample still at the new level.
REQ-023 Counter SHALL not wrap: N up to 2^DEB_W-1 SHALL qualify correctly.
REQ-024 en_i=0 SHALL gate trig_p_o/trig_n_o to 0 and freeze gcnt_o; FSM and trig_lvl_o SHALL keep tracking.
REQ-025 Each glitch event with en_i=1 SHALL increment gcnt_o by 1, saturating at all-ones.
REQ-026 gcnt_clr_i=1 SHALL set gcnt_o to 0 next cycle, taking priority over a simultaneous glitch increment.

Reset
REQ-027 adc_rstn_i low SHALL immediately force: synchronizer flops 0, state STABLE_LO, counter 0, trig_p_o 0, trig_n_o 0, trig_lvl_o 0, gcnt_o 0.
REQ-028 Reset asserted mid-qualification SHALL discard progress; no pulse SHALL emit on or after reset release until a fresh full qualification.
REQ-029 If trig_ext_i is high at reset release, a trig_p_o SHALL follow after N+1 edges per REQ-019.

Structure
REQ-030 FSM state encodings and DEB_W/GCNT_W defaults SHALL live in the shared package red_pitaya_trig_pkg, reused by the scope trigger logic.
REQ-031 Synchronizer SHALL be sub-module red_pitaya_sync2 (two flops, async active-low reset, width parameter).
REQ-032 Implementation SHALL be 120-400 lines RTL total.

Verification
REQ-033 deb_len_i=4, trig_ext_i 0->1 held 20 cycles -> single trig_p_o pulse exactly 5 edges after first sampling edge, trig_lvl_o=1, gcnt_o=0.
REQ-034 deb_len_i=10, trig_ext_i high 3 cycles then low -> no trig_p_o, trig_lvl_o stays 0, gcnt_o=1.
REQ-035 deb_len_i=0, 1-cycle-high/1-cycle-low toggling x8 -> behaves as N=1, alternating trig_p_o/trig_n_o, never simultaneous.
REQ-036 GCNT_W=4, 20 glitches with deb_len_i=8 -> gcnt_o saturates at 15; gcnt_clr_i coincident with glitch -> gcnt_o=0.
REQ-037 deb_len_i=100, reset pulsed at qualification count 50 while input stays high -> no pulse until 101 edges after reset release, then one trig_p_o.
REQ-038 en_i=0 during full 0->1->0 qualification -> no pulses, trig_lvl_o tracks 1 then 0, gcnt_o unchanged.

Source files
------------

// File: rtl/red_pitaya_trig_pkg.sv
// Shared definitions for the external-trigger debounce and the scope trigger logic:
// FSM state encoding, default widths and a small state-decoding helper.
package red_pitaya_trig_pkg;

  localparam int TRIG_DEB_W  = 20;
  localparam int TRIG_GCNT_W = 16;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_QUAL_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_QUAL_LO   = 2'd3
  } trig_state_e;

  // The debounced level stays high while a falling transition is only being qualified.
  function automatic logic is_high_state(input trig_state_e st);
    return (st == ST_STABLE_HI) || (st == ST_QUAL_LO);
  endfunction

endpackage

// File: rtl/red_pitaya_sync2.sv
// Two-flop synchronizer for bringing asynchronous signals into the local clock domain.
module red_pitaya_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/red_pitaya_trig_debounce.sv
// External trigger debounce: synchronizes the raw pin, qualifies each level change for
// N clocks, emits edge pulses, a debounced level and a saturating count of rejected glitches.
module red_pitaya_trig_debounce
  import red_pitaya_trig_pkg::*;
#(
  parameter int DEB_W  = TRIG_DEB_W,
  parameter int GCNT_W = TRIG_GCNT_W
) (
  input  logic              adc_clk_i,
  input  logic              adc_rstn_i,
  input  logic              trig_ext_i,
  input  logic [DEB_W-1:0]  deb_len_i,
  input  logic              en_i,
  input  logic              gcnt_clr_i,
  output logic              trig_p_o,
  output logic              trig_n_o,
  output logic              trig_lvl_o,
  output logic [GCNT_W-1:0] gcnt_o,
  output trig_state_e       fsm_state
);

  logic             s;
  trig_state_e      state, state_nx;
  logic [DEB_W-1:0] cnt, cnt_nx;
  logic [DEB_W-1:0] len_eff;
  logic [DEB_W:0]   cnt_inc;
  logic             len_one;
  logic             qual_done;
  logic             glitch;
  logic             rise, fall;

  red_pitaya_sync2 #(
    .W (1)
  ) u_sync (
    .clk   (adc_clk_i),
    .rst_n (adc_rstn_i),
    .d     (trig_ext_i),
    .q     (s)
  );

  // A programmed length of zero behaves as one; the extra MSB on the increment keeps
  // the comparison exact when N sits at the top of the counter range.
  assign len_eff   = (deb_len_i == '0) ? DEB_W'(1) : deb_len_i;
  assign len_one   = (len_eff == DEB_W'(1));
  assign cnt_inc   = {1'b0, cnt} + (DEB_W + 1)'(1);
  assign qual_done = (cnt_inc >= {1'b0, len_eff});

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state <= ST_STABLE_LO;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    glitch   = 1'b0;
    case (state)
      ST_STABLE_LO: begin
        if (s) begin
          if (len_one) begin
            state_nx = ST_STABLE_HI;
          end else begin
            state_nx = ST_QUAL_HI;
            cnt_nx   = DEB_W'(1);
          end
        end
      end
      ST_QUAL_HI: begin
        if (!s) begin
          state_nx = ST_STABLE_LO;
          cnt_nx   = '0;
          glitch   = 1'b1;
        end else if (qual_done) begin
          state_nx = ST_STABLE_HI;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc[DEB_W-1:0];
        end
      end
      ST_STABLE_HI: begin
        if (!s) begin
          if (len_one) begin
            state_nx = ST_STABLE_LO;
          end else begin
            state_nx = ST_QUAL_LO;
            cnt_nx   = DEB_W'(1);
          end
        end
      end
      ST_QUAL_LO: begin
        if (s) begin
          state_nx = ST_STABLE_HI;
          cnt_nx   = '0;
          glitch   = 1'b1;
        end else if (qual_done) begin
          state_nx = ST_STABLE_LO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc[DEB_W-1:0];
        end
      end
      default: begin
        state_nx = ST_STABLE_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  // A return from a qualifying state to its stable origin is a glitch, never an edge.
  assign rise = (state_nx == ST_STABLE_HI) &&
                ((state == ST_STABLE_LO) || (state == ST_QUAL_HI));
  assign fall = (state_nx == ST_STABLE_LO) &&
                ((state == ST_STABLE_HI) || (state == ST_QUAL_LO));

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      trig_p_o   <= 1'b0;
      trig_n_o   <= 1'b0;
      trig_lvl_o <= 1'b0;
    end else begin
      trig_p_o   <= en_i & rise;
      trig_n_o   <= en_i & fall;
      trig_lvl_o <= is_high_state(state_nx);
    end
  end

  // Clear wins over a coincident glitch; counting stops at all-ones.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      gcnt_o <= '0;
    end else if (gcnt_clr_i) begin
      gcnt_o <= '0;
    end else if (en_i && glitch && (gcnt_o != '1)) begin
      gcnt_o <= gcnt_o + GCNT_W'(1);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_red_pitaya_trig_debounce.sv
// Bench for the trigger debounce: directed scenarios plus random stimulus, all checked
// against a run-length model of the qualification rules.
module tb_red_pitaya_trig_debounce;
  import red_pitaya_trig_pkg::*;

  localparam int DW = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          en = 1'b1;
  logic          clr = 1'b0;
  logic [DW-1:0] deb_len = DW'(4);
  logic          trig_p, trig_n, trig_lvl;
  logic [GW-1:0] gcnt;
  trig_state_e   dut_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model state
  logic          m_s1, m_s2, m_lvl, m_p, m_n;
  int            m_run;
  logic [GW-1:0] m_g;

  red_pitaya_trig_debounce #(
    .DEB_W  (DW),
    .GCNT_W (GW)
  ) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rst_n),
    .trig_ext_i (trig),
    .deb_len_i  (deb_len),
    .en_i       (en),
    .gcnt_clr_i (clr),
    .trig_p_o   (trig_p),
    .trig_n_o   (trig_n),
    .trig_lvl_o (trig_lvl),
    .gcnt_o     (gcnt),
    .fsm_state  (dut_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_p = 1'b0; m_n = 1'b0;
    m_run = 0; m_g = '0;
  endtask

  // One clock: the model counts consecutive synchronized samples that disagree with the
  // debounced level and flips once the run reaches the live length.
  task automatic tick();
    int   n;
    logic smp, flip, glitch;
    @(posedge clk);
    if (rst_n) begin
      n      = (deb_len == '0) ? 1 : int'(deb_len);
      smp    = m_s2;
      m_s2   = m_s1;
      m_s1   = trig;
      flip   = 1'b0;
      glitch = 1'b0;
      if (smp != m_lvl) begin
        m_run++;
        if (m_run >= n) begin
          flip  = 1'b1;
          m_lvl = smp;
          m_run = 0;
        end
      end else begin
        if (m_run > 0) glitch = 1'b1;
        m_run = 0;
      end
      m_p = en && flip && m_lvl;
      m_n = en && flip && !m_lvl;
      if (clr) m_g = '0;
      else if (en && glitch && m_g != '1) m_g = m_g + 1'b1;
    end
    #1;
  endtask

  task automatic settle_low();
    deb_len = DW'(1); trig = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 1'b1; model_reset();
    #2;
    vec_cnt++;
    if ({trig_p, trig_n, trig_lvl, gcnt} !== 7'd0 || dut_state !== ST_STABLE_LO) begin
      err_cnt++;
      $display("FAIL reset_async got=%b state=%0d want=0000000 state=0", {trig_p, trig_n, trig_lvl, gcnt}, dut_state);
    end
    repeat (3) tick();
    vec_cnt++;
    if ({trig_p, trig_n, trig_lvl, gcnt} !== 7'd0 || dut_state !== ST_STABLE_LO) begin
      err_cnt++;
      $display("FAIL reset_held got=%b state=%0d want=0000000 state=0", {trig_p, trig_n, trig_lvl, gcnt}, dut_state);
    end
    trig = 1'b0; rst_n = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      vec_cnt++;
      if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
        err_cnt++;
        $display("FAIL reset_release t=%0d got=%b want=%b", t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
      end
    end
  endtask

  task automatic test_qual_n4();
    int first, npulse;
    settle_low();
    deb_len = DW'(4); trig = 1'b1; first = -1; npulse = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      vec_cnt++;
      if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
        err_cnt++;
        $display("FAIL qual_n4 t=%0d got=%b want=%b", t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
      end
      if (trig_p) begin
        npulse++;
        if (first < 0) first = t;
      end
    end
    vec_cnt++;
    if (first != 6 || npulse != 1) begin
      err_cnt++;
      $display("FAIL qual_n4_latency first_edge=%0d pulses=%0d want first_edge=6 pulses=1", first, npulse);
    end
    vec_cnt++;
    if (trig_lvl !== 1'b1 || gcnt !== 4'd0) begin
      err_cnt++;
      $display("FAIL qual_n4_final lvl=%b gcnt=%0d want lvl=1 gcnt=0", trig_lvl, gcnt);
    end
  endtask

  task automatic test_glitch();
    int npulse;
    logic saw_hi;
    settle_low();
    deb_len = DW'(10); npulse = 0; saw_hi = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      trig = (t <= 3);
      tick();
      vec_cnt++;
      if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
        err_cnt++;
        $display("FAIL glitch t=%0d got=%b want=%b", t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
      end
      if (trig_p) npulse++;
      if (trig_lvl) saw_hi = 1'b1;
    end
    vec_cnt++;
    if (npulse != 0 || saw_hi || gcnt !== 4'd1) begin
      err_cnt++;
      $display("FAIL glitch_result pulses=%0d lvl_seen_hi=%b gcnt=%0d want 0 0 1", npulse, saw_hi, gcnt);
    end
  endtask

  task automatic test_toggle_n0();
    int np, nn, both;
    settle_low();
    deb_len = '0; np = 0; nn = 0; both = 0;
    for (int t = 1; t <= 20; t++) begin
      trig = (t <= 16) && (t % 2 == 1);
      tick();
      vec_cnt++;
      if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
        err_cnt++;
        $display("FAIL toggle_n0 t=%0d got=%b want=%b", t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
      end
      np += int'(trig_p);
      nn += int'(trig_n);
      if (trig_p && trig_n) both++;
    end
    vec_cnt++;
    if (np != 8 || nn != 8 || both != 0) begin
      err_cnt++;
      $display("FAIL toggle_n0_counts p=%0d n=%0d both=%0d want 8 8 0", np, nn, both);
    end
  endtask

  task automatic test_gcnt_sat();
    settle_low();
    deb_len = DW'(8);
    for (int g = 0; g < 20; g++) begin
      for (int t = 1; t <= 8; t++) begin
        trig = (t <= 3);
        tick();
        vec_cnt++;
        if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
          err_cnt++;
          $display("FAIL gcnt_sat g=%0d t=%0d got=%b want=%b", g, t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
        end
      end
    end
    vec_cnt++;
    if (gcnt !== 4'd15) begin
      err_cnt++;
      $display("FAIL gcnt_saturate got=%0d want=15", gcnt);
    end
    // the glitch is detected on the sixth edge after the pin rises for three clocks
    trig = 1'b1; repeat (3) tick();
    trig = 1'b0; repeat (2) tick();
    clr = 1'b1; tick();
    clr = 1'b0;
    vec_cnt++;
    if (gcnt !== 4'd0 || m_g !== 4'd0) begin
      err_cnt++;
      $display("FAIL gcnt_clr_priority got=%0d model=%0d want=0", gcnt, m_g);
    end
    repeat (3) tick();
    vec_cnt++;
    if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
      err_cnt++;
      $display("FAIL gcnt_after_clr got=%b want=%b", {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
    end
  endtask

  task automatic test_en_gate();
    int npulse;
    logic saw_hi;
    logic [GW-1:0] g0;
    settle_low();
    deb_len = DW'(3);
    trig = 1'b1; tick(); trig = 1'b0; repeat (5) tick();
    g0 = 4'd1;
    vec_cnt++;
    if (gcnt !== g0) begin
      err_cnt++;
      $display("FAIL en_gate_setup gcnt=%0d want=1", gcnt);
    end
    en = 1'b0; npulse = 0; saw_hi = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      trig = (t <= 10) || (t == 21);
      tick();
      vec_cnt++;
      if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
        err_cnt++;
        $display("FAIL en_gate t=%0d got=%b want=%b", t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
      end
      npulse += int'(trig_p) + int'(trig_n);
      if (trig_lvl) saw_hi = 1'b1;
    end
    vec_cnt++;
    if (npulse != 0 || !saw_hi || trig_lvl !== 1'b0 || gcnt !== g0) begin
      err_cnt++;
      $display("FAIL en_gate_result pulses=%0d saw_hi=%b lvl=%b gcnt=%0d want 0 1 0 %0d", npulse, saw_hi, trig_lvl, gcnt, g0);
    end
    en = 1'b1;
  endtask

  task automatic test_live_len();
    int npulse;
    settle_low();
    deb_len = DW'(50); trig = 1'b1; npulse = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      npulse += int'(trig_p);
    end
    deb_len = DW'(5);
    tick();
    vec_cnt++;
    if (npulse != 0 || trig_p !== 1'b1 || trig_lvl !== 1'b1) begin
      err_cnt++;
      $display("FAIL live_len early=%0d p=%b lvl=%b want 0 1 1", npulse, trig_p, trig_lvl);
    end
    vec_cnt++;
    if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
      err_cnt++;
      $display("FAIL live_len_model got=%b want=%b", {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
    end
  endtask

  task automatic test_long_len(input int n, input logic mid_reset);
    int first, npulse;
    settle_low();
    deb_len = DW'(n); trig = 1'b1;
    if (mid_reset) begin
      // counter reaches 50 on the 52nd edge
      repeat (52) tick();
      rst_n = 1'b0; model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
    end
    first = -1; npulse = 0;
    for (int t = 1; t <= n + 6; t++) begin
      tick();
      if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g}) begin
        err_cnt++;
        $display("FAIL long_len n=%0d t=%0d got=%b want=%b", n, t, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
      end
      vec_cnt++;
      if (trig_p) begin
        npulse++;
        if (first < 0) first = t;
      end
    end
    vec_cnt++;
    if (first != n + 2 || npulse != 1 || trig_lvl !== 1'b1) begin
      err_cnt++;
      $display("FAIL long_len_latency n=%0d first_edge=%0d pulses=%0d lvl=%b want %0d 1 1", n, first, npulse, trig_lvl, n + 2);
    end
  endtask

  task automatic test_random();
    int hold;
    settle_low();
    deb_len = DW'($urandom_range(0, 6));
    for (int seg = 0; seg < 250; seg++) begin
      trig = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) deb_len = DW'($urandom_range(0, 6));
      for (int t = 0; t < hold; t++) begin
        en  = ($urandom_range(0, 7) != 0);
        clr = ($urandom_range(0, 15) == 0);
        tick();
        vec_cnt++;
        if ({trig_p, trig_n, trig_lvl, gcnt} !== {m_p, m_n, m_lvl, m_g} || (trig_p && trig_n)) begin
          err_cnt++;
          $display("FAIL random seg=%0d t=%0d len=%0d got=%b want=%b", seg, t, deb_len, {trig_p, trig_n, trig_lvl, gcnt}, {m_p, m_n, m_lvl, m_g});
        end
      end
    end
    en = 1'b1; clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_qual_n4();
    test_glitch();
    test_toggle_n0();
    test_gcnt_sat();
    test_en_gate();
    test_live_len();
    test_long_len(100, 1'b1);
    test_long_len(255, 1'b0);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
